// File: rtl/shift_seq_pkg.sv
// Shared state encoding and defaults for the shift-add multiplier sequencer.
package shift_seq_pkg;

  localparam int SEQ_N_DEF = 14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/shift_seq_controller_step_counter.sv
// Step counter for the shift sequencer: synchronous clear/increment with a
// terminal flag on the last shift step (N-1).
module step_counter
  import shift_seq_pkg::*;
#(
  parameter int  N     = SEQ_N_DEF,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign term = (cnt_q == CNT_W'(N - 1));

endmodule

// File: rtl/shift_seq_controller.sv
// Load/shift/done sequencer for the shift-right register of a shift-add multiplier.
// Optional early termination on an all-zero register: `define SHIFT_SEQ_EARLY_TERM_EN.
module shift_seq_controller
  import shift_seq_pkg::*;
#(
  parameter int  N     = SEQ_N_DEF,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             sr_lsb,
  input  logic             sr_zero,
  output logic             load_en,
  output logic             shift_en,
  output logic             add_en,
  output logic             clr_acc,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] step_cnt
);

  seq_state_e state_q, state_d;
  logic       cnt_clr, cnt_inc, cnt_term, early_stop;

`ifdef SHIFT_SEQ_EARLY_TERM_EN
  assign early_stop = sr_zero;
`else
  logic unused_sr_zero;
  assign early_stop     = 1'b0;
  assign unused_sr_zero = sr_zero;
`endif

  step_counter #(.N(N)) u_step_counter (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .cnt  (step_cnt),
    .term (cnt_term)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        cnt_clr = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        cnt_inc = 1'b1;
        if (cnt_term || early_stop) state_d = ST_DONE;
      end
      // held start chains straight into the next load
      ST_DONE: state_d = start ? ST_LOAD : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
    end
  end

  assign load_en  = (state_q == ST_LOAD);
  assign clr_acc  = (state_q == ST_LOAD);
  assign shift_en = (state_q == ST_EXEC);
  assign done     = (state_q == ST_DONE);
  assign busy     = (state_q != ST_IDLE);
  assign add_en   = shift_en & sr_lsb & ~early_stop;

endmodule

// File: tb/tb_shift_seq_controller.sv
// Directed self-checking bench for shift_seq_controller (N=14); follows
// SHIFT_SEQ_EARLY_TERM_EN for the early-termination expectations.
module tb_shift_seq_controller;

  localparam int N     = 14;
  localparam int CNT_W = 4;

`ifdef SHIFT_SEQ_EARLY_TERM_EN
  localparam int EXP_DONE = 6;
  localparam int EXP_CNT  = 4;
  localparam int EXP_ADD5 = 0;
`else
  localparam int EXP_DONE = 16;
  localparam int EXP_CNT  = 14;
  localparam int EXP_ADD5 = 1;
`endif

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
  logic sr_lsb = 1'b0, sr_zero = 1'b0;
  logic load_en, shift_en, add_en, clr_acc, busy, done;
  logic [CNT_W-1:0] step_cnt;

  int checks = 0;
  int errors = 0;

  shift_seq_controller #(.N(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .sr_lsb  (sr_lsb),
    .sr_zero (sr_zero),
    .load_en (load_en),
    .shift_en(shift_en),
    .add_en  (add_en),
    .clr_acc (clr_acc),
    .busy    (busy),
    .done    (done),
    .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // advance one cycle and check the per-cycle invariants
  task automatic step();
    @(posedge clk);
    #1;
    chk("excl_load_shift_done", 32'($countones({load_en, shift_en, done}) <= 1), 1);
    chk("excl_clr_shift_done", 32'($countones({clr_acc, shift_en, done}) <= 1), 1);
    if (load_en || shift_en || done) chk("busy_with_strobe", busy, 1);
    if (add_en) chk("add_needs_shift", shift_en, 1);
  endtask

  initial begin
    int seen;
    int n_d, n_l, done_off, cnt_at;
    int d_off[3];
    int l_off[3];

    // reset state
    #2 reset = 1'b1;
    #1;
    chk("rst_outputs", {load_en, shift_en, add_en, clr_acc, busy, done}, 0);
    chk("rst_cnt", step_cnt, 0);
    step(); step();
    chk("rst_hold_outputs", {load_en, shift_en, add_en, clr_acc, busy, done}, 0);
    reset = 1'b0;
    step();

    // test 1: reset mid-EXEC at step 5
    start = 1'b1; step(); start = 1'b0;
    chk("t1_load", load_en, 1);
    repeat (6) step();
    chk("t1_cnt5", step_cnt, 5);
    chk("t1_shift", shift_en, 1);
    reset = 1'b1;
    #1;
    chk("t1_rst_outputs", {load_en, shift_en, add_en, clr_acc, busy, done}, 0);
    chk("t1_rst_cnt", step_cnt, 0);
    seen = 0;
    repeat (3) begin step(); if (done) seen = 1; end
    chk("t1_no_done", seen, 0);
    reset = 1'b0;
    step();

    // test 2: full op, sr_lsb alternating 1,0,1,...
    start = 1'b1; step(); start = 1'b0;
    chk("t2_load", load_en, 1);
    chk("t2_clr_acc", clr_acc, 1);
    for (int i = 0; i < N; i++) begin
      step();
      sr_lsb = (i % 2 == 0);
      #1;
      chk("t2_shift", shift_en, 1);
      chk("t2_add", add_en, (i % 2 == 0) ? 1 : 0);
      chk("t2_cnt", step_cnt, i);
    end
    step();
    sr_lsb = 1'b0;
    chk("t2_done", done, 1);
    chk("t2_done_cnt", step_cnt, 14);
    chk("t2_done_noshift", shift_en, 0);
    step();
    chk("t2_after_done", {done, busy}, 0);

    // test 3: start held high -> back-to-back operations
    n_d = 0; n_l = 0;
    start = 1'b1;
    for (int off = 1; off <= 50; off++) begin
      step();
      if (off == 40) start = 1'b0;
      if (done)    begin if (n_d < 3) d_off[n_d] = off; n_d++; end
      if (load_en) begin if (n_l < 3) l_off[n_l] = off; n_l++; end
    end
    chk("t3_n_done", n_d, 3);
    chk("t3_done0", d_off[0], 16);
    chk("t3_done1", d_off[1], 32);
    chk("t3_done2", d_off[2], 48);
    chk("t3_n_load", n_l, 3);
    chk("t3_load0", l_off[0], 1);
    chk("t3_load1", l_off[1], 17);
    chk("t3_load2", l_off[2], 33);
    chk("t3_idle_end", busy, 0);

    // test 4: abort at step 7, start ignored while busy
    start = 1'b1; step(); start = 1'b0;
    n_l = 0;
    for (int off = 2; off <= 9; off++) begin
      step();
      if (off == 4) start = 1'b1;
      if (off == 6) start = 1'b0;
      if (load_en) n_l++;
    end
    chk("t4_no_reload", n_l, 0);
    chk("t4_cnt7", step_cnt, 7);
    chk("t4_shift", shift_en, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_idle", busy, 0);
    chk("t4_no_done", done, 0);
    chk("t4_cnt_hold", step_cnt, 7);
    seen = 0;
    repeat (4) begin step(); if (done || load_en) seen = 1; end
    chk("t4_quiet", seen, 0);
    chk("t4_cnt_hold2", step_cnt, 7);

    // test 5: sr_zero rises after step 3
    start = 1'b1; step(); start = 1'b0;
    done_off = -1; cnt_at = 0;
    for (int off = 2; off <= 20; off++) begin
      step();
      sr_zero = (off >= 5);
      sr_lsb  = 1'b1;
      #1;
      if (off == 5) chk("t5_add_at_zero", add_en, EXP_ADD5);
      if (done && done_off < 0) begin done_off = off; cnt_at = int'(step_cnt); end
    end
    sr_zero = 1'b0; sr_lsb = 1'b0;
    chk("t5_done_at", done_off, EXP_DONE);
    chk("t5_cnt", cnt_at, EXP_CNT);
    chk("t5_idle_end", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
